// File: rtl/game_pkg.sv
// Shared definitions for the tank game controller.
//   game_state_e  : top-level game phase (SELECT / FIGHT / OVER)
//   Key*          : USB HID keycodes the controller reacts to
//   TankW/H, Cooldown defaults and the tank-index wrap helper
package game_pkg;

  typedef enum logic [1:0] {
    StSelect = 2'b00,
    StFight  = 2'b01,
    StOver   = 2'b10
  } game_state_e;

  localparam logic [7:0] KeyA     = 8'h04;
  localparam logic [7:0] KeyD     = 8'h07;
  localparam logic [7:0] KeyRight = 8'h4F;
  localparam logic [7:0] KeyLeft  = 8'h50;
  localparam logic [7:0] KeyEnter = 8'h28;

  localparam int unsigned TankWDefault   = 70;
  localparam int unsigned TankHDefault   = 50;
  localparam int unsigned CooldownFrames = 30;

  // Step a sprite index up or down, wrapping within 0..last.
  function automatic logic [1:0] tank_step(input logic [1:0] cur, input logic up,
                                           input logic [1:0] last);
    if (up) begin
      return (cur >= last) ? 2'd0 : cur + 2'd1;
    end else begin
      return (cur == 2'd0) ? last : cur - 2'd1;
    end
  endfunction

endpackage

// File: rtl/hit_detect.sv
// Combinational bullet-in-box test for one shooter/target pair.
//   tank_x, tank_y     : target tank top-left corner (10 bit)
//   bullet_x, bullet_y : bullet centre (10 bit)
//   hit                : bullet lies inside [0..TANK_W] x [0..TANK_H] of the tank
module hit_detect #(
  parameter int unsigned TANK_W = 70,
  parameter int unsigned TANK_H = 50
) (
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [9:0] bullet_x,
  input  logic [9:0] bullet_y,
  output logic       hit
);

  localparam logic signed [10:0] ExtW = 11'(TANK_W);
  localparam logic signed [10:0] ExtH = 11'(TANK_H);

  logic signed [10:0] dx;
  logic signed [10:0] dy;

  // Zero-extend to 11 bits so the difference sign is meaningful.
  assign dx = $signed({1'b0, bullet_x}) - $signed({1'b0, tank_x});
  assign dy = $signed({1'b0, bullet_y}) - $signed({1'b0, tank_y});

  assign hit = !dx[10] && (dx <= ExtW) && !dy[10] && (dy <= ExtH);

endmodule

// File: rtl/game_state_ctrl.sv
// Game phase controller: tank selection, fight with life tracking, game-over hold.
//   Clk, Reset_n            : clock, asynchronous active-low reset
//   frame_tick              : one-cycle pulse per video frame
//   keycode                 : current HID keycode (0 = none)
//   TankX/Y_A/B, BulletX/Y_A/B : sprite positions
//   currentState            : 00 SELECT, 01 FIGHT, 10 OVER
//   currentTank_A/B, lives_A/B, hit_A/B, winner : game status outputs
// Optional feature: define HIT_COOLDOWN_EN to ignore repeat hits on a tank for
// 30 frames after each hit.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned NUM_TANKS   = 3,
  parameter int unsigned OVER_FRAMES = 120,
  parameter int unsigned TANK_W      = TankWDefault,
  parameter int unsigned TANK_H      = TankHDefault
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [9:0] TankX_A,
  input  logic [9:0] TankY_A,
  input  logic [9:0] TankX_B,
  input  logic [9:0] TankY_B,
  input  logic [9:0] BulletX_A,
  input  logic [9:0] BulletY_A,
  input  logic [9:0] BulletX_B,
  input  logic [9:0] BulletY_B,
  output logic [1:0] currentState,
  output logic [1:0] currentTank_A,
  output logic [1:0] currentTank_B,
  output logic [1:0] lives_A,
  output logic [1:0] lives_B,
  output logic       hit_A,
  output logic       hit_B,
  output logic       winner
);

  localparam logic [1:0]  LivesInit = 2'(LIVES);
  localparam logic [1:0]  TankLast  = 2'(NUM_TANKS - 1);
  localparam int unsigned OverCntW  = $clog2(OVER_FRAMES + 1);
  localparam logic [OverCntW-1:0] OverLast = OverCntW'(OVER_FRAMES);

  game_state_e         state_q, state_d;
  logic [7:0]          key_q;
  logic [1:0]          tank_a_q, tank_a_d, tank_b_q, tank_b_d;
  logic [1:0]          lives_a_q, lives_a_d, lives_b_q, lives_b_d;
  logic                hit_a_q, hit_a_d, hit_b_q, hit_b_d;
  logic                winner_q, winner_d;
  logic [OverCntW-1:0] over_cnt_q, over_cnt_d, over_cnt_inc;
  logic                key_press;
  logic                hit_on_a, hit_on_b;

`ifdef HIT_COOLDOWN_EN
  localparam logic [4:0] CdLoad = 5'(CooldownFrames - 1);
  logic [4:0] cd_a_q, cd_a_d, cd_b_q, cd_b_d;
`endif

  // Bullet B against tank A, bullet A against tank B.
  hit_detect #(.TANK_W(TANK_W), .TANK_H(TANK_H)) u_hit_on_a (
    .tank_x  (TankX_A),
    .tank_y  (TankY_A),
    .bullet_x(BulletX_B),
    .bullet_y(BulletY_B),
    .hit     (hit_on_a)
  );

  hit_detect #(.TANK_W(TANK_W), .TANK_H(TANK_H)) u_hit_on_b (
    .tank_x  (TankX_B),
    .tank_y  (TankY_B),
    .bullet_x(BulletX_A),
    .bullet_y(BulletY_A),
    .hit     (hit_on_b)
  );

  // A held key only registers on its first cycle.
  assign key_press    = (keycode != 8'h00) && (keycode != key_q);
  assign over_cnt_inc = over_cnt_q + OverCntW'(1);

  always_comb begin
    state_d    = state_q;
    tank_a_d   = tank_a_q;
    tank_b_d   = tank_b_q;
    lives_a_d  = lives_a_q;
    lives_b_d  = lives_b_q;
    hit_a_d    = 1'b0;
    hit_b_d    = 1'b0;
    winner_d   = winner_q;
    over_cnt_d = over_cnt_q;
`ifdef HIT_COOLDOWN_EN
    cd_a_d     = cd_a_q;
    cd_b_d     = cd_b_q;
`endif

    case (state_q)
      StSelect: begin
        if (key_press) begin
          case (keycode)
            KeyA:     tank_a_d = tank_step(tank_a_q, 1'b0, TankLast);
            KeyD:     tank_a_d = tank_step(tank_a_q, 1'b1, TankLast);
            KeyLeft:  tank_b_d = tank_step(tank_b_q, 1'b0, TankLast);
            KeyRight: tank_b_d = tank_step(tank_b_q, 1'b1, TankLast);
            KeyEnter: begin
              state_d   = StFight;
              lives_a_d = LivesInit;
              lives_b_d = LivesInit;
`ifdef HIT_COOLDOWN_EN
              cd_a_d    = '0;
              cd_b_d    = '0;
`endif
            end
            default: ;
          endcase
        end
      end

      StFight: begin
        if (frame_tick) begin
`ifdef HIT_COOLDOWN_EN
          // Load 29 so the 30th following frame is the first accepted again.
          hit_a_d = hit_on_a && (cd_a_q == '0);
          hit_b_d = hit_on_b && (cd_b_q == '0);
          cd_a_d  = (cd_a_q != '0) ? cd_a_q - 5'd1 : (hit_a_d ? CdLoad : 5'd0);
          cd_b_d  = (cd_b_q != '0) ? cd_b_q - 5'd1 : (hit_b_d ? CdLoad : 5'd0);
`else
          hit_a_d = hit_on_a;
          hit_b_d = hit_on_b;
`endif
          lives_a_d = lives_a_q - {1'b0, hit_a_d};
          lives_b_d = lives_b_q - {1'b0, hit_b_d};
          if ((lives_a_d == 2'd0) || (lives_b_d == 2'd0)) begin
            state_d    = StOver;
            // Simultaneous knock-out resolves to A.
            winner_d   = (lives_a_d == 2'd0) && (lives_b_d != 2'd0);
            over_cnt_d = '0;
          end
        end
      end

      StOver: begin
        if (frame_tick) begin
          over_cnt_d = over_cnt_inc;
        end
        if ((frame_tick && (over_cnt_inc == OverLast)) ||
            (key_press && (keycode == KeyEnter))) begin
          state_d = StSelect;
        end
      end

      default: state_d = StSelect;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StSelect;
      key_q      <= 8'h00;
      tank_a_q   <= 2'd0;
      tank_b_q   <= 2'd1;
      lives_a_q  <= LivesInit;
      lives_b_q  <= LivesInit;
      hit_a_q    <= 1'b0;
      hit_b_q    <= 1'b0;
      winner_q   <= 1'b0;
      over_cnt_q <= '0;
`ifdef HIT_COOLDOWN_EN
      cd_a_q     <= '0;
      cd_b_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      key_q      <= keycode;
      tank_a_q   <= tank_a_d;
      tank_b_q   <= tank_b_d;
      lives_a_q  <= lives_a_d;
      lives_b_q  <= lives_b_d;
      hit_a_q    <= hit_a_d;
      hit_b_q    <= hit_b_d;
      winner_q   <= winner_d;
      over_cnt_q <= over_cnt_d;
`ifdef HIT_COOLDOWN_EN
      cd_a_q     <= cd_a_d;
      cd_b_q     <= cd_b_d;
`endif
    end
  end

  assign currentState  = state_q;
  assign currentTank_A = tank_a_q;
  assign currentTank_B = tank_b_q;
  assign lives_A       = lives_a_q;
  assign lives_B       = lives_b_q;
  assign hit_A         = hit_a_q;
  assign hit_B         = hit_b_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with default parameters.
module tb_game_state_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] TankX_A = 10'd100, TankY_A = 10'd200, TankX_B = 10'd400, TankY_B = 10'd100;
  logic [9:0] BulletX_A = 10'd0, BulletY_A = 10'd0, BulletX_B = 10'd0, BulletY_B = 10'd0;
  logic [1:0] currentState, currentTank_A, currentTank_B, lives_A, lives_B;
  logic       hit_A, hit_B, winner;

  int n_checks = 0;
  int n_fail   = 0;

  game_state_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .keycode      (keycode),
    .TankX_A      (TankX_A),
    .TankY_A      (TankY_A),
    .TankX_B      (TankX_B),
    .TankY_B      (TankY_B),
    .BulletX_A    (BulletX_A),
    .BulletY_A    (BulletY_A),
    .BulletX_B    (BulletX_B),
    .BulletY_B    (BulletY_B),
    .currentState (currentState),
    .currentTank_A(currentTank_A),
    .currentTank_B(currentTank_B),
    .lives_A      (lives_A),
    .lives_B      (lives_B),
    .hit_A        (hit_A),
    .hit_B        (hit_B),
    .winner       (winner)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    step();
    keycode = 8'h00;
    step();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic bullets_away();
    BulletX_A = 10'd0;
    BulletY_A = 10'd0;
    BulletX_B = 10'd0;
    BulletY_B = 10'd0;
  endtask

  // Frames with no bullet in any box; lets any hit cooldown expire.
  task automatic idle_frames(input int n);
    bullets_away();
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (currentState !== 2'b00) begin n_fail++; $display("FAIL rst_state: got %0d want 0", currentState); end
    n_checks++; if (currentTank_A !== 2'd0) begin n_fail++; $display("FAIL rst_tank_a: got %0d want 0", currentTank_A); end
    n_checks++; if (currentTank_B !== 2'd1) begin n_fail++; $display("FAIL rst_tank_b: got %0d want 1", currentTank_B); end
    n_checks++; if (lives_A !== 2'd3 || lives_B !== 2'd3) begin n_fail++; $display("FAIL rst_lives: got %0d/%0d want 3/3", lives_A, lives_B); end
    n_checks++; if (hit_A !== 1'b0 || hit_B !== 1'b0 || winner !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got %b%b%b want 000", hit_A, hit_B, winner); end
    step();
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_held_key();
    keycode = 8'h07;
    for (int i = 0; i < 10; i++) step();
    keycode = 8'h00;
    step();
    n_checks++; if (currentTank_A !== 2'd1) begin n_fail++; $display("FAIL held_key: got %0d want 1", currentTank_A); end
  endtask

  task automatic test_select_wrap();
    press(8'h4F);
    n_checks++; if (currentTank_B !== 2'd2) begin n_fail++; $display("FAIL b_inc: got %0d want 2", currentTank_B); end
    press(8'h4F);
    n_checks++; if (currentTank_B !== 2'd0) begin n_fail++; $display("FAIL b_wrap_up: got %0d want 0", currentTank_B); end
    press(8'h50);
    n_checks++; if (currentTank_B !== 2'd2) begin n_fail++; $display("FAIL b_wrap_down: got %0d want 2", currentTank_B); end
    press(8'h4F);
    press(8'h04);
    n_checks++; if (currentTank_A !== 2'd0) begin n_fail++; $display("FAIL a_dec: got %0d want 0", currentTank_A); end
    press(8'h04);
    n_checks++; if (currentTank_A !== 2'd2) begin n_fail++; $display("FAIL a_wrap_down: got %0d want 2", currentTank_A); end
    press(8'h07);
    press(8'h07);
    press(8'h05);
    n_checks++; if (currentTank_A !== 2'd1 || currentTank_B !== 2'd0 || currentState !== 2'b00) begin
      n_fail++; $display("FAIL other_key: got %0d/%0d st %0d want 1/0 st 0", currentTank_A, currentTank_B, currentState);
    end
  endtask

  task automatic test_fight_hits();
    keycode = 8'h28;
    step();
    n_checks++; if (currentState !== 2'b01 || lives_A !== 2'd3 || lives_B !== 2'd3) begin
      n_fail++; $display("FAIL enter_fight: got st %0d lives %0d/%0d want st 1 lives 3/3", currentState, lives_A, lives_B);
    end
    keycode = 8'h00;
    step();
    // Tank key in FIGHT is ignored.
    press(8'h07);
    n_checks++; if (currentTank_A !== 2'd1) begin n_fail++; $display("FAIL fight_tank_key: got %0d want 1", currentTank_A); end
    // Far corner of A's box, no frame tick yet.
    BulletX_B = 10'd170;
    BulletY_B = 10'd250;
    step();
    step();
    n_checks++; if (hit_A !== 1'b0 || lives_A !== 2'd3) begin n_fail++; $display("FAIL no_tick: got hit %b lives %0d want 0 3", hit_A, lives_A); end
    frame();
    n_checks++; if (hit_A !== 1'b1 || hit_B !== 1'b0 || lives_A !== 2'd2) begin
      n_fail++; $display("FAIL corner_hit: got hit %b%b lives %0d want 10 2", hit_A, hit_B, lives_A);
    end
    step();
    n_checks++; if (hit_A !== 1'b0 || lives_A !== 2'd2) begin n_fail++; $display("FAIL hit_pulse: got hit %b lives %0d want 0 2", hit_A, lives_A); end
    BulletX_B = 10'd171;
    BulletY_B = 10'd200;
    frame();
    n_checks++; if (hit_A !== 1'b0 || lives_A !== 2'd2) begin n_fail++; $display("FAIL edge_miss: got hit %b lives %0d want 0 2", hit_A, lives_A); end
    idle_frames(30);
    BulletX_A = 10'd400;
    BulletY_A = 10'd100;
    frame();
    n_checks++; if (hit_B !== 1'b1 || hit_A !== 1'b0 || lives_B !== 2'd2) begin
      n_fail++; $display("FAIL hit_b: got hit %b%b lives_b %0d want 01 2", hit_A, hit_B, lives_B);
    end
    idle_frames(30);
    BulletX_A = 10'd430; BulletY_A = 10'd120; BulletX_B = 10'd130; BulletY_B = 10'd220;
    frame();
    n_checks++; if (hit_A !== 1'b1 || hit_B !== 1'b1 || lives_A !== 2'd1 || lives_B !== 2'd1 || currentState !== 2'b01) begin
      n_fail++; $display("FAIL both_hit: got hit %b%b lives %0d/%0d st %0d want 11 1/1 st 1", hit_A, hit_B, lives_A, lives_B, currentState);
    end
    idle_frames(30);
    BulletX_A = 10'd430; BulletY_A = 10'd120; BulletX_B = 10'd130; BulletY_B = 10'd220;
    frame();
    n_checks++; if (hit_A !== 1'b1 || hit_B !== 1'b1 || currentState !== 2'b10 || winner !== 1'b0) begin
      n_fail++; $display("FAIL double_ko: got hit %b%b st %0d winner %b want 11 st 2 winner 0", hit_A, hit_B, currentState, winner);
    end
    for (int i = 0; i < 119; i++) frame();
    n_checks++; if (currentState !== 2'b10) begin n_fail++; $display("FAIL over_hold: got %0d want 2", currentState); end
    frame();
    n_checks++; if (currentState !== 2'b00) begin n_fail++; $display("FAIL over_timeout: got %0d want 0", currentState); end
    n_checks++; if (currentTank_A !== 2'd1 || currentTank_B !== 2'd0) begin
      n_fail++; $display("FAIL tank_persist: got %0d/%0d want 1/0", currentTank_A, currentTank_B);
    end
    bullets_away();
  endtask

  task automatic test_reset_mid_fight();
    press(8'h28);
    BulletX_B = 10'd120;
    BulletY_B = 10'd220;
    frame();
    n_checks++; if (hit_A !== 1'b1 || lives_A !== 2'd2) begin n_fail++; $display("FAIL pre_reset_hit: got hit %b lives %0d want 1 2", hit_A, lives_A); end
    #2;
    Reset_n = 1'b0;
    #1;
    n_checks++; if (currentState !== 2'b00 || hit_A !== 1'b0 || lives_A !== 2'd3 || currentTank_A !== 2'd0 || currentTank_B !== 2'd1) begin
      n_fail++; $display("FAIL async_reset: got st %0d hit %b lives %0d tanks %0d/%0d want 0 0 3 0/1", currentState, hit_A, lives_A, currentTank_A, currentTank_B);
    end
    #3;
    Reset_n = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n_checks++; if (hit_A !== 1'b0 || lives_A !== 2'd3 || currentState !== 2'b00) begin
      n_fail++; $display("FAIL release_edge: got hit %b lives %0d st %0d want 0 3 0", hit_A, lives_A, currentState);
    end
  endtask

  task automatic test_parked_bullet();
    int hits;
    press(8'h28);
    BulletX_B = 10'd120;
    BulletY_B = 10'd220;
    hits = 0;
`ifdef HIT_COOLDOWN_EN
    for (int i = 0; i < 31; i++) begin
      frame();
      if (hit_A === 1'b1) hits++;
    end
    n_checks++; if (hits !== 2 || lives_A !== 2'd1 || currentState !== 2'b01) begin
      n_fail++; $display("FAIL cooldown: got hits %0d lives %0d st %0d want 2 1 1", hits, lives_A, currentState);
    end
`else
    for (int i = 0; i < 3; i++) begin
      frame();
      if (hit_A === 1'b1) hits++;
    end
    n_checks++; if (hits !== 3 || lives_A !== 2'd0 || currentState !== 2'b10 || winner !== 1'b1) begin
      n_fail++; $display("FAIL parked: got hits %0d lives %0d st %0d winner %b want 3 0 2 1", hits, lives_A, currentState, winner);
    end
    press(8'h28);
    n_checks++; if (currentState !== 2'b00) begin n_fail++; $display("FAIL over_enter: got %0d want 0", currentState); end
`endif
  endtask

  initial begin
    test_reset();
    test_held_key();
    test_select_wrap();
    test_fight_hits();
    test_reset_mid_fight();
    test_parked_bullet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3, meaning lives per tank at fight start (1..3).
REQ-002 SHALL have parameter NUM_TANKS, default 3, meaning selectable tank sprites (index 0..NUM_TANKS-1).
REQ-003 SHALL have parameter OVER_FRAMES, default 120, meaning frames held in OVER before returning to SELECT.
REQ-004 SHALL have parameter TANK_W/TANK_H, default 70/50, meaning tank hit-box extent in pixels.
REQ-005 Clk  input  1  system clock; the block has one clock.
REQ-006 Reset_n  input  1  reset, asynchronous and active-low.
REQ-007 frame_tick  input  1  one-Clk pulse per frame (vsync rising edge, synchronised upstream).
REQ-008 keycode  input  8  current USB HID keycode, 0 = no key.
REQ-009 TankX_A, TankY_A, TankX_B, TankY_B  input  10 each  tank top-left positions.
REQ-010 BulletX_A, BulletY_A, BulletX_B, BulletY_B  input  10 each  bullet centres.
REQ-011 currentState  output  2  00 SELECT, 01 FIGHT, 10 OVER, registered.
REQ-012 currentTank_A, currentTank_B  output  2 each  selected sprite index, registered.
REQ-013 lives_A, lives_B  output  2 each  remaining lives, registered.
REQ-014 hit_A, hit_B  output  1 each  one-Clk pulse when that tank loses a life.
REQ-015 winner  output  1  0 = A won, 1 = B won; valid in OVER.

Function
REQ-016 Key press = keycode nonzero and differing from the previous-Clk registered keycode; held keys SHALL act once.
REQ-017 SELECT: 0x04 (A) / 0x07 (D) decrement/increment currentTank_A; 0x50 / 0x4F (arrows) do the same for currentTank_B; both wrap modulo NUM_TANKS.
REQ-018 SELECT: press 0x28 (Enter) -> FIGHT next Clk; lives_A = lives_B = LIVES loaded on the same edge.
REQ-019 FIGHT: hit evaluated only on Clk with frame_tick=1; bullet B hits A when 0 <= BulletX_B-TankX_A <= TANK_W and 0 <= BulletY_B-TankY_A <= TANK_H (11-bit signed differences); symmetric for A hitting B.
REQ-020 On a hit, lives decrement by 1 and hit_x pulses on the same edge; both tanks hit in one frame -> both decrement.
REQ-021 FIGHT -> OVER when any lives reach 0; winner = tank with lives remaining; both reaching 0 on the same frame -> winner = 0.
REQ-022 OVER: frame counter counts frame_tick; after OVER_FRAMES ticks or Enter press, -> SELECT; counter cleared on OVER entry.
REQ-023 currentTank_A/B SHALL persist across FIGHT/OVER and return to SELECT unchanged.
REQ-024 Keys other than those listed SHALL be ignored; tank keys ignored outside SELECT.
REQ-025 State encoding 2'b11 is illegal; if reached, -> SELECT next Clk.

Reset
REQ-026 Reset_n low asynchronously forces: currentState=SELECT, currentTank_A=0, currentTank_B=1, lives_A=lives_B=LIVES, hit_A=hit_B=0, winner=0, counters and key register 0.
REQ-027 Reset asserted mid-FIGHT or mid-OVER SHALL abort immediately; no hit pulse on the release edge.

Configuration
REQ-028 Macro HIT_COOLDOWN_EN defined: after a hit on tank X, further hits on X ignored for 30 frame_ticks (per-tank 5-bit counter, cleared on FIGHT entry and reset).
REQ-029 HIT_COOLDOWN_EN undefined: every qualifying frame produces a hit; no cooldown counters exist.

Structure
REQ-030 Shared package game_pkg SHALL hold the state enum (SELECT, FIGHT, OVER), keycode constants, and the TANK_W/TANK_H/cooldown defaults.
REQ-031 Sub-module hit_detect (one instance per direction) SHALL perform the combinational bullet-in-box test.

Verification
REQ-032 Reset, keycode 0x07 held 10 Clk then 0 -> currentTank_A 0->1 exactly once.
REQ-033 SELECT, currentTank_B=2, press 0x4F -> currentTank_B=0 (wrap).
REQ-034 Enter, then BulletB=(TankX_A+70, TankY_A+50) on frame_tick -> hit_A single pulse, lives_A 3->2; at (TankX_A+71, TankY_A) -> no hit.
REQ-035 Both bullets inside opposite tanks with lives 1/1 -> both hit pulses, OVER, winner=0; after 120 frame_ticks -> SELECT.
REQ-036 With HIT_COOLDOWN_EN, bullet parked in tank A for 31 frames -> exactly two hits (frames 0 and 30); without it, lives_A reaches 0 after 3 frames.
REQ-037 Reset_n pulsed low mid-FIGHT between Clk edges -> outputs at reset values immediately, currentState=00.
